// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 data mux.
// Define RR_ARB_TIMEOUT_EN to force rotation after HOLD_MAX grant cycles when others wait.
module rr_mux_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       dout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_mux_arbiter: HOLD_MAX must be within 1..255");
  end

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] cand;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             new_grant;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // Candidates never include the current owner; in IDLE gnt_q is zero so all requests compete.
  assign cand = req & ~gnt_q;

  // First candidate in order ptr, ptr+1, ptr+2, ptr+3 (scan backwards so the lowest offset wins).
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = ptr_q + IDX_W'(k);
      if (cand[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        new_grant = win_vld;
      end
      S_GRANT: begin
        if (req[sel_q]) begin
`ifdef RR_ARB_TIMEOUT_EN
          if (hold_cnt_q == HOLD_LAST) begin
            new_grant = win_vld;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
`endif
        end else if (win_vld) begin
          new_grant = 1'b1;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (new_grant) begin
      state_d = S_GRANT;
      gnt_d   = N_REQ'(1) << win_idx;
      sel_d   = win_idx;
      ptr_d   = win_idx + IDX_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == S_GRANT);

  // sel[0] picks within a pair, sel[1] picks the pair.
  always_comb begin
    dout = 1'b0;
    if (busy) begin
      dout = sel_q[1] ? (sel_q[0] ? din[3] : din[2])
                      : (sel_q[0] ? din[1] : din[0]);
    end
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, maximum grant cycles before forced rotation, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req, input, 4 bits, request line per requester; req[i] belongs to requester i.
REQ-005 The block SHALL have port din, input, 4 bits, data bit per requester; din[i] belongs to requester i.
REQ-006 The block SHALL have port gnt, output, 4 bits, registered one-hot grant, or all-zero when there is no owner.
REQ-007 The block SHALL have port sel, output, 2 bits, registered binary index of the owner, used as the shared 4:1 mux select (sel[0] picks within a pair, sel[1] picks the pair).
REQ-008 The block SHALL have port busy, output, 1 bit, high while in state GRANT.
REQ-009 The block SHALL have port dout, output, 1 bit, equal to din[sel] when busy is high, 0 otherwise (combinational from din).

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and GRANT (exactly one owner).
REQ-011 A 2-bit priority pointer ptr SHALL define the search order ptr, ptr+1, ptr+2, ptr+3, wrapping mod 4; the first asserted req in that order wins.
REQ-012 In IDLE with any req bit high at edge N, the block SHALL enter GRANT at edge N with gnt/sel for the winner visible after that edge, giving 1-cycle latency.
REQ-013 On every new grant to requester i, ptr SHALL become (i+1) mod 4 and hold_cnt SHALL clear to 0.
REQ-014 In GRANT, while req[owner] stays high, gnt and sel SHALL hold, and hold_cnt SHALL increment each cycle, saturating at HOLD_MAX-1.
REQ-015 In GRANT, if req[owner] is low at an edge and another req is high, the block SHALL grant the next winner at that same edge with no idle bubble.
REQ-016 In GRANT, if req[owner] is low and no other req is high, the block SHALL return to IDLE with gnt=0, busy=0 and sel holding its last value.
REQ-017 gnt SHALL never have more than one bit set, and gnt[sel] SHALL be 1 whenever busy is 1.
REQ-018 Simultaneous requests SHALL be resolved only by ptr order; no requester SHALL wait more than 3 other grants while its req is held.
REQ-019 A req bit that deasserts before being granted SHALL be dropped, with no memory of the request.

Reset
REQ-020 When rst_n is low at an edge: state SHALL be IDLE, gnt=4'b0000, sel=2'b00, busy=0, ptr=0, hold_cnt=0; dout SHALL therefore be 0.
REQ-021 Reset during GRANT SHALL drop the grant at that edge regardless of req; arbitration SHALL resume on the first edge with rst_n high.

Configuration
REQ-022 Macro RR_ARB_TIMEOUT_EN defined: in GRANT, when hold_cnt==HOLD_MAX-1, req[owner] is high and any other req is high, the block SHALL grant the next winner excluding the owner at the next edge. If no other req is high, the owner SHALL keep the grant with hold_cnt saturated.
REQ-023 Macro RR_ARB_TIMEOUT_EN undefined: the owner SHALL keep the grant until its req drops, HOLD_MAX SHALL have no effect, and the hold_cnt logic SHALL be omitted.

Verification
REQ-024 Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0000, sel=00, busy=0, dout=0; release rst_n -> gnt=0001 one edge later.
REQ-025 Rotation: req=4'b1111 held, each owner drops req for 1 cycle after its grant -> grant order 0,1,2,3,0 with no idle cycles between grants.
REQ-026 Mux path: owner=2, din=4'b0100 -> dout=1; din=4'b1011 -> dout=0; return to IDLE -> dout=0 for any din.
REQ-027 Timeout (RR_ARB_TIMEOUT_EN, HOLD_MAX=4): req=4'b0011 held -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, then 0001 again; with req=4'b0001 alone -> gnt=0001 indefinitely.
REQ-028 Timeout off (macro undefined): req=4'b0011 held for 50 cycles -> gnt=0001 throughout.
REQ-029 Wrap and empty: owner=3 releases while req=4'b0001 -> gnt=0001 at the same edge and ptr=1; then req=0 -> IDLE, busy=0, sel=00.
